uart_tx_periph: RTL and testbench

//   Memory-mapped UART transmitter; a bus responder on the 65C02 CPU bus alongside RAM, BIOS and VGA.
//   CPU writes bytes into a TX FIFO; an 8N1 serializer drains the FIFO onto tx_o at a programmable bit rate.

---
 rtl/uart_tx_periph.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_periph.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter for the 65C02 bus: a byte FIFO written by the CPU,
// drained by a serializer at a programmable bit period (divisor+1 clocks per bit).
module uart_tx_periph #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [15:0] DIV_RESET = 16'd60
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       we_i,
    input  logic [1:0] addr_i,
    input  logic [7:0] din_i,
    output logic [7:0] dout_o,
    output logic       tx_o,
    output logic       irq_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    logic [7:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    state_t      state;
    logic [7:0]  shreg;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [15:0] divisor;
    logic        ovr;

    logic       fifo_empty;
    logic       fifo_full;
    logic       pop;
    logic       push_req;
    logic       push_ok;
    logic       drop;
    logic       busy;
    logic [4:0] count_ext;
    logic [3:0] count_sat;
    logic [7:0] status;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(DEPTH));
    assign pop        = (state == ST_IDLE) && !fifo_empty;
    assign push_req   = en_i && we_i && (addr_i == 2'd0);
    // A full FIFO still accepts a byte when the serializer pops in the same cycle
    assign push_ok    = push_req && (!fifo_full || pop);
    assign drop       = push_req && !push_ok;
    assign busy       = (state != ST_IDLE) || !fifo_empty;
    assign count_ext  = 5'(count);
    assign count_sat  = (count_ext > 5'd15) ? 4'hF : count_ext[3:0];
    assign status     = {count_sat, ovr, busy, fifo_empty, fifo_full};

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push_ok) fifo_mem[wr_ptr] <= din_i;
    end

    // CPU-visible registers and registered read data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            divisor <= DIV_RESET;
            ovr     <= 1'b0;
            dout_o  <= 8'h00;
        end else begin
            if (en_i && we_i) begin
                case (addr_i)
                    2'd1:    if (din_i[3]) ovr <= 1'b0;
                    2'd2:    divisor[7:0]  <= din_i;
                    2'd3:    divisor[15:8] <= din_i;
                    default: ;
                endcase
            end
            if (drop) ovr <= 1'b1;
            if (en_i && !we_i) begin
                case (addr_i)
                    2'd0:    dout_o <= 8'h00;
                    2'd1:    dout_o <= status;
                    2'd2:    dout_o <= divisor[7:0];
                    default: dout_o <= divisor[15:8];
                endcase
            end
        end
    end

    // Serializer; the divisor is reloaded at the start of every bit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            tx_o    <= 1'b1;
            irq_o   <= 1'b0;
            shreg   <= 8'h00;
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
        end else begin
            irq_o <= (state == ST_IDLE) && fifo_empty;
            case (state)
                ST_IDLE: begin
                    tx_o <= 1'b1;
                    if (!fifo_empty) begin
                        shreg   <= fifo_mem[rd_ptr];
                        bit_cnt <= divisor;
                        tx_o    <= 1'b0;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_cnt == 16'd0) begin
                        bit_cnt <= divisor;
                        bit_idx <= 3'd0;
                        tx_o    <= shreg[0];
                        state   <= ST_DATA;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt == 16'd0) begin
                        bit_cnt <= divisor;
                        if (bit_idx == 3'd7) begin
                            tx_o  <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx_o    <= shreg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_cnt == 16'd0) state <= ST_IDLE;
                    else                  bit_cnt <= bit_cnt - 16'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph: bytes written are queued as expected frames and compared
// cycle-by-cycle against the decoded serial waveform; register reads checked against constants.
module tb_uart_tx_periph;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       en_i = 1'b0;
    logic       we_i = 1'b0;
    logic [1:0] addr_i = 2'd0;
    logic [7:0] din_i = 8'h00;
    logic [7:0] dout_o;
    logic       tx_o;
    logic       irq_o;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    logic [7:0] sb [$];

    uart_tx_periph #(.DEPTH(8), .DIV_RESET(16'd60)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (en_i),
        .we_i  (we_i),
        .addr_i(addr_i),
        .din_i (din_i),
        .dout_o(dout_o),
        .tx_o  (tx_o),
        .irq_o (irq_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge
    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        en_i = 1'b1; we_i = 1'b1; addr_i = a; din_i = d;
        @(negedge clk_i);
        en_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        en_i = 1'b1; we_i = 1'b0; addr_i = a;
        @(negedge clk_i);
        en_i = 1'b0;
        d = dout_o;
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        check(tag, 32'(d), 32'(exp));
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        sb.delete();
        @(negedge clk_i);
    endtask

    // Receive one frame; slots below split last dur_a cycles, the rest dur_b
    task automatic rx_frame(input int dur_a, input int dur_b, input int split,
                            output int t_start, output int t_end, output int irq_hi);
        int waited;
        int bad;
        int d;
        logic eb;
        logic [7:0] exp;
        logic [7:0] got;
        waited = 0; bad = 0; irq_hi = 0; got = 8'h00;
        while (tx_o !== 1'b0 && waited < 4000) begin
            @(negedge clk_i);
            waited++;
        end
        t_start = cyc;
        t_end = cyc;
        if (tx_o !== 1'b0) begin
            check("rx_start_timeout", 32'(tx_o), 32'd0);
            return;
        end
        check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        for (int k = 0; k < 10; k++) begin
            d = (k < split) ? dur_a : dur_b;
            eb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : exp[k-1];
            for (int c = 0; c < d; c++) begin
                if (!(k == 0 && c == 0)) @(negedge clk_i);
                if (tx_o !== eb) bad++;
                if (irq_o) irq_hi++;
                if (k >= 1 && k <= 8 && c == d / 2) got[k-1] = tx_o;
            end
        end
        t_end = cyc;
        check("frame_data", 32'(got), 32'(exp));
        check("frame_wave_bad_cycles", 32'(bad), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s1, e1, s2, e2, ih;
        int w5;
        @(negedge clk_i);
        do_reset();

        // Reset state
        check("reset_tx", 32'(tx_o), 32'd1);
        check("reset_irq", 32'(irq_o), 32'd1);
        check("reset_dout", 32'(dout_o), 32'h00);
        read_check("reset_status", 2'd1, 8'h02);

        // Divisor registers after reset and write-back
        read_check("divl_reset", 2'd2, 8'h3C);
        read_check("divh_reset", 2'd3, 8'h00);
        bus_write(2'd3, 8'h01);
        read_check("divh_write", 2'd3, 8'h01);
        bus_write(2'd3, 8'h00);

        // Single frame at divisor 3
        bus_write(2'd2, 8'd3);
        sb.push_back(8'hA5);
        bus_write(2'd0, 8'hA5);
        rx_frame(4, 4, 10, s1, e1, ih);
        check("irq_during_frame", 32'(ih), 32'd0);
        repeat (2) @(negedge clk_i);
        check("irq_after_frame", 32'(irq_o), 32'd1);
        check("tx_idle_after_frame", 32'(tx_o), 32'd1);
        read_check("status_after_frame", 2'd1, 8'h02);

        // Back-to-back frames at divisor 0
        bus_write(2'd2, 8'd0);
        sb.push_back(8'h00);
        bus_write(2'd0, 8'h00);
        sb.push_back(8'hFF);
        bus_write(2'd0, 8'hFF);
        rx_frame(1, 1, 10, s1, e1, ih);
        rx_frame(1, 1, 10, s2, e2, ih);
        check("idle_gap", 32'(s2 - e1), 32'd2);
        check("two_frame_span", 32'(e2 - s1 + 1), 32'd21);

        // FIFO fill, overflow and ovr clear at divisor 100
        bus_write(2'd2, 8'd100);
        fork
            begin
                int a, b, c;
                for (int i = 0; i < 9; i++) rx_frame(101, 101, 10, a, b, c);
            end
            begin
                for (int i = 0; i < 9; i++) begin
                    sb.push_back(8'h30 + 8'(i));
                    bus_write(2'd0, 8'h30 + 8'(i));
                end
                read_check("status_full", 2'd1, 8'h85);
                bus_write(2'd0, 8'hEE);
                read_check("status_ovr", 2'd1, 8'h8D);
                bus_write(2'd1, 8'h08);
                read_check("status_ovr_clr", 2'd1, 8'h85);
            end
        join

        // Divisor change 3 -> 7 in the middle of data bit 2
        bus_write(2'd2, 8'd3);
        sb.push_back(8'h96);
        bus_write(2'd0, 8'h96);
        fork
            rx_frame(4, 8, 4, s1, e1, ih);
            begin
                int w;
                w = 0;
                while (tx_o !== 1'b0 && w < 4000) begin
                    @(negedge clk_i);
                    w++;
                end
                repeat (13) @(negedge clk_i);
                bus_write(2'd2, 8'd7);
            end
        join

        // Reset during the DATA state
        bus_write(2'd2, 8'd3);
        bus_write(2'd0, 8'h5A);
        w5 = 0;
        while (tx_o !== 1'b0 && w5 < 4000) begin
            @(negedge clk_i);
            w5++;
        end
        check("midreset_frame_started", 32'(tx_o), 32'd0);
        repeat (9) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        sb.delete();
        check("midreset_tx", 32'(tx_o), 32'd1);
        read_check("midreset_status", 2'd1, 8'h02);
        read_check("midreset_divl", 2'd2, 8'h3C);
        check("midreset_irq", 32'(irq_o), 32'd1);
        repeat (20) @(negedge clk_i);
        check("midreset_tx_quiet", 32'(tx_o), 32'd1);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
